// File: rtl/quad_step_decoder_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
//   Shared types and the transition classifier for the quadrature step decoder.
//   Imported by quad_glitch_filter and quad_step_decoder.
//
//   quad_state_t   : decoder FSM state (INIT waits for a first stable value,
//                    TRACK classifies every accepted change)
//   quad_ab_t      : packed {A, B} phase pair
//   quad_class_t   : result of classifying one prev -> cur transition
//   quad_classify  : maps a prev -> cur pair onto NONE / UP / DOWN / ILLEGAL
// -----------------------------------------------------------------------------
package quad_pkg;

  typedef enum logic [0:0] {QS_INIT, QS_TRACK} quad_state_t;

  typedef logic [1:0] quad_ab_t;

  typedef enum logic [1:0] {QC_NONE, QC_UP, QC_DOWN, QC_ILLEGAL} quad_class_t;

  // Up direction walks the Gray cycle 00 -> 01 -> 11 -> 10 -> 00.
  // Any single-bit change not in that list is the reverse direction; a
  // two-bit change cannot come from a real encoder and is flagged illegal.
  function automatic quad_class_t quad_classify(input quad_ab_t prev,
                                                input quad_ab_t cur);
    quad_class_t cls;
    cls = QC_NONE;
    if ((prev ^ cur) == 2'b11) begin
      cls = QC_ILLEGAL;
    end else if (prev != cur) begin
      case ({prev, cur})
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: cls = QC_UP;
        default:                                cls = QC_DOWN;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// -----------------------------------------------------------------------------
// quad_step_decoder_if
//   Signal bundle between the encoder-side driver and the step decoder.
//   Optional feature macro: QUAD_POSITION_EN adds the signed position bus and
//   its POS_WIDTH parameter.
//
//   quad_a, quad_b : encoder phases (asynchronous to clk)
//   err_clear      : clears the sticky error flag
//   step_en        : one-cycle step pulse
//   step_up        : step direction, 1 = up (valid with step_en)
//   err            : sticky illegal-transition flag
//   position       : signed running count (QUAD_POSITION_EN only)
//
//   master : drives the phases and err_clear, observes the decoder outputs
//   slave  : the decoder side
// -----------------------------------------------------------------------------
interface quad_step_decoder_if
`ifdef QUAD_POSITION_EN
  #(parameter int POS_WIDTH = 32)
`endif
  ;
  logic quad_a;
  logic quad_b;
  logic err_clear;
  logic step_en;
  logic step_up;
  logic err;

`ifdef QUAD_POSITION_EN
  logic signed [POS_WIDTH-1:0] position;

  modport master (output quad_a, quad_b, err_clear,
                  input  step_en, step_up, err, position);
  modport slave  (input  quad_a, quad_b, err_clear,
                  output step_en, step_up, err, position);
`else
  modport master (output quad_a, quad_b, err_clear,
                  input  step_en, step_up, err);
  modport slave  (input  quad_a, quad_b, err_clear,
                  output step_en, step_up, err);
`endif

endinterface

// File: rtl/quad_step_decoder_glitch_filter.sv
// -----------------------------------------------------------------------------
// quad_glitch_filter
//   Two-flop synchroniser on each phase followed by a stability filter.
//   A new {A,B} value is accepted onto ab_f_o only after the synchronised
//   input has matched the candidate for FILTER_LEN further clocks; valid_o
//   pulses once per accepted value.
//
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset (clears sync, candidate, counter)
//   ab_i     : raw {A, B} from the pins
//   ab_f_o   : last accepted (filtered) {A, B}
//   valid_o  : one-cycle pulse when ab_f_o is (re)loaded
// -----------------------------------------------------------------------------
module quad_glitch_filter
  import quad_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  quad_ab_t ab_i,
  output quad_ab_t ab_f_o,
  output logic     valid_o
);

  // Counter reaches FILTER_LEN-1 to accept, then parks at FILTER_LEN so the
  // same candidate never produces a second valid pulse.
  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FILTER_LEN);

  quad_ab_t         sync1_q, sync2_q;
  quad_ab_t         cand_q, cand_d;
  quad_ab_t         ab_f_q, ab_f_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    ab_f_d  = ab_f_q;
    valid_d = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_LAST) begin
      ab_f_d  = cand_q;
      valid_d = 1'b1;
      cnt_d   = CNT_DONE;
    end else if (cnt_q != CNT_DONE) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // stage: synchroniser, then candidate/counter, then filtered output
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      ab_f_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= ab_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      ab_f_q  <= ab_f_d;
      valid_q <= valid_d;
    end
  end

  assign ab_f_o  = ab_f_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/quad_step_decoder.sv
// -----------------------------------------------------------------------------
// quad_step_decoder
//   Turns a Gray-coded A/B quadrature pair into registered one-cycle step
//   commands (step_en + step_up) for an up/down position counter, and raises
//   a sticky err on any two-bit (illegal) transition.
//   Optional feature macro: QUAD_POSITION_EN adds a signed POS_WIDTH running
//   position that follows the step outputs one clock later.
//
//   clk   : rising-edge clock, single domain
//   reset : synchronous active-high reset
//   bus   : quad_step_decoder_if.slave
//           in : quad_a, quad_b, err_clear
//           out: step_en, step_up, err, position (QUAD_POSITION_EN only)
//
//   Latency from the first synchroniser capture of a stable change to step_en
//   is 2 + FILTER_LEN + 1 clocks.
// -----------------------------------------------------------------------------
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int FILTER_LEN = 4
`ifdef QUAD_POSITION_EN
  ,
  parameter int POS_WIDTH  = 32
`endif
) (
  input logic                 clk,
  input logic                 reset,
  quad_step_decoder_if.slave  bus
);

  quad_ab_t    ab_f;
  logic        f_valid;
  quad_class_t cls;

  quad_glitch_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk     (clk),
    .reset   (reset),
    .ab_i    ({bus.quad_a, bus.quad_b}),
    .ab_f_o  (ab_f),
    .valid_o (f_valid)
  );

  quad_state_t state_q, state_d;
  quad_ab_t    prev_q, prev_d;
  logic        step_en_q, step_en_d;
  logic        step_up_q, step_up_d;
  logic        err_q, err_d;

  assign cls = quad_classify(prev_q, ab_f);

  // The filter re-pulses valid after a rejected glitch with ab_f unchanged;
  // the classifier returns NONE in that case so no step is issued.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    step_en_d = 1'b0;
    step_up_d = step_up_q;
    err_d     = err_q;
    // Clear first so a coincident illegal transition still sets err.
    if (bus.err_clear) begin
      err_d = 1'b0;
    end
    case (state_q)
      QS_INIT: begin
        if (f_valid) begin
          prev_d  = ab_f;
          state_d = QS_TRACK;
        end
      end
      QS_TRACK: begin
        if (f_valid) begin
          prev_d = ab_f;
          case (cls)
            QC_UP: begin
              step_en_d = 1'b1;
              step_up_d = 1'b1;
            end
            QC_DOWN: begin
              step_en_d = 1'b1;
              step_up_d = 1'b0;
            end
            QC_ILLEGAL: begin
              err_d = 1'b1;
            end
            default: begin
            end
          endcase
        end
      end
      default: begin
        state_d = QS_INIT;
      end
    endcase
  end

  // stage: registered decoder state and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= QS_INIT;
      prev_q    <= '0;
      step_en_q <= 1'b0;
      step_up_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      step_en_q <= step_en_d;
      step_up_q <= step_up_d;
      err_q     <= err_d;
    end
  end

  assign bus.step_en = step_en_q;
  assign bus.step_up = step_up_q;
  assign bus.err     = err_q;

`ifdef QUAD_POSITION_EN
  localparam logic signed [POS_WIDTH-1:0] POS_ONE = 1;

  logic signed [POS_WIDTH-1:0] pos_q, pos_d;

  // Follows the registered step, so position moves one clock after step_en.
  always_comb begin
    pos_d = pos_q;
    if (step_en_q) begin
      pos_d = step_up_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
    end
  end

  // stage: position accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign bus.position = pos_q;
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
`timescale 1ns/1ps
module tb_quad_step_decoder;

  localparam int FL = 4;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

`ifdef QUAD_POSITION_EN
  quad_step_decoder_if #(.POS_WIDTH(PW)) bus ();
  quad_step_decoder #(.FILTER_LEN(FL), .POS_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`else
  quad_step_decoder_if bus ();
  quad_step_decoder #(.FILTER_LEN(FL)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  // Gray position of an {A,B} pair on the up cycle 00,01,11,10 and back.
  function automatic int gpos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray(input int p);
    logic [1:0] b;
    b = 2'(p & 3);
    return {b[1], b[1] ^ b[0]};
  endfunction

  // ---------------- reference model ----------------
  // Delay line for the synchroniser, run length of identical synchronised
  // samples for the filter (FL+1 equal samples accept a value), Gray
  // position difference for direction.
  logic [1:0]  m_s1, m_s2, m_run_val, m_acc_val, m_prev;
  int          m_run_len;
  logic        m_acc, m_seeded, m_en, m_up, m_err;
  logic [PW-1:0] m_pos;

  always @(posedge clk) begin : model
    logic [1:0] smp;
    int         d;
    logic       nacc;
    if (reset) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_run_val = 2'b00; m_run_len = 1;
      m_acc = 1'b0; m_acc_val = 2'b00; m_seeded = 1'b0; m_prev = 2'b00;
      m_en = 1'b0; m_up = 1'b0; m_err = 1'b0; m_pos = '0;
    end else begin
      if (m_en) m_pos = m_up ? m_pos + 1 : m_pos - 1;
      m_en = 1'b0;
      if (bus.err_clear) m_err = 1'b0;
      if (m_acc) begin
        if (!m_seeded) begin
          m_seeded = 1'b1;
          m_prev   = m_acc_val;
        end else if (m_acc_val != m_prev) begin
          d = (gpos(m_acc_val) - gpos(m_prev)) & 3;
          if (d == 2) m_err = 1'b1;
          else begin
            m_en = 1'b1;
            m_up = (d == 1);
          end
          m_prev = m_acc_val;
        end
      end
      smp  = m_s2;
      nacc = 1'b0;
      if (smp == m_run_val) begin
        if (m_run_len <= FL) begin
          m_run_len++;
          nacc = (m_run_len == FL + 1);
        end
      end else begin
        m_run_val = smp;
        m_run_len = 1;
      end
      m_acc     = nacc;
      m_acc_val = m_run_val;
      m_s2      = m_s1;
      m_s1      = {bus.quad_a, bus.quad_b};
    end
  end

  task automatic tick(input logic [1:0] ab, input logic clr, input logic rst);
    bus.quad_a    = ab[1];
    bus.quad_b    = ab[0];
    bus.err_clear = clr;
    reset         = rst;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(2'b11, 1'b0, 1'b1);
      n_checks++;
      if ({bus.step_en, bus.step_up, bus.err} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d: en/up/err=%b%b%b expected 000", i, bus.step_en, bus.step_up, bus.err);
      end
`ifdef QUAD_POSITION_EN
      n_checks++;
      if (bus.position !== '0) begin
        n_fail++;
        $display("FAIL reset_position: got %0h expected 0", bus.position);
      end
`endif
    end
    for (int i = 0; i < 10; i++) begin
      tick(2'b11, 1'b0, 1'b0);
      n_checks++;
      if (bus.step_en !== 1'b0 || bus.err !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_seed cyc%0d: en=%b err=%b expected 0 0", i, bus.step_en, bus.err);
      end
      n_checks++;
      if ({bus.step_en, bus.step_up, bus.err} !== {m_en, m_up, m_err}) begin
        n_fail++;
        $display("FAIL reset_model cyc%0d: en/up/err=%b%b%b expected %b%b%b", i, bus.step_en, bus.step_up, bus.err, m_en, m_up, m_err);
      end
    end
  endtask

  // up=1: reseed at 00 then 01,11,10,00; up=0: 10,11,01,00 then one more down.
  task automatic test_sequence(input bit up);
    int pulses, hold;
    logic [1:0] ab;
    pulses = 0;
    if (up) begin
      tick(2'b00, 1'b0, 1'b1);
      tick(2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) tick(2'b00, 1'b0, 1'b0);
    end
    for (int k = 1; k <= 5; k++) begin
      if (up && k == 5) break;
      ab   = up ? gray(k) : gray(4 - k);
      hold = 8 + int'($urandom_range(0, 4));
      for (int i = 0; i < hold; i++) begin
        tick(ab, 1'b0, 1'b0);
        if (bus.step_en === 1'b1) pulses++;
        n_checks++;
        if (bus.step_en !== (i == 7) || (i == 7 && bus.step_up !== up)) begin
          n_fail++;
          $display("FAIL seq_latency dir%0d step%0d cyc%0d: en=%b up=%b expected en=%b up=%b", up, k, i, bus.step_en, bus.step_up, (i == 7), up);
        end
        n_checks++;
        if ({bus.step_en, bus.step_up, bus.err} !== {m_en, m_up, m_err}) begin
          n_fail++;
          $display("FAIL seq_model dir%0d cyc%0d: en/up/err=%b%b%b expected %b%b%b", up, i, bus.step_en, bus.step_up, bus.err, m_en, m_up, m_err);
        end
      end
      if (k == 4) begin
        tick(ab, 1'b0, 1'b0);
        tick(ab, 1'b0, 1'b0);
        n_checks++;
        if (pulses !== 4) begin
          n_fail++;
          $display("FAIL seq_pulse_count dir%0d: got %0d expected 4", up, pulses);
        end
`ifdef QUAD_POSITION_EN
        n_checks++;
        if (bus.position !== (up ? 32'sd4 : 32'sd0)) begin
          n_fail++;
          $display("FAIL seq_position dir%0d: got %0h expected %0h", up, bus.position, (up ? 4 : 0));
        end
`endif
      end
    end
    if (!up) begin
      tick(2'b10, 1'b0, 1'b0);
      tick(2'b10, 1'b0, 1'b0);
      n_checks++;
      if (bus.step_en !== 1'b0 || bus.step_up !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_step_hold: en=%b up=%b expected 0 0", bus.step_en, bus.step_up);
      end
`ifdef QUAD_POSITION_EN
      n_checks++;
      if (bus.position !== 32'shFFFFFFFF) begin
        n_fail++;
        $display("FAIL wrap_position: got %0h expected ffffffff", bus.position);
      end
`endif
    end
  endtask

  task automatic test_glitch();
    logic [1:0] gl;
    int pulses;
    logic [1:0] ups;
    for (int i = 0; i < 10; i++) tick(2'b00, 1'b0, 1'b0);
    for (int g = 0; g < 2; g++) begin
      gl = (g == 0) ? 2'b10 : 2'b01;
      for (int i = 0; i < 13; i++) begin
        tick((i < FL - 1) ? gl : 2'b00, 1'b0, 1'b0);
        n_checks++;
        if (bus.step_en !== 1'b0 || bus.err !== 1'b0) begin
          n_fail++;
          $display("FAIL glitch_reject g%0d cyc%0d: en=%b err=%b expected 0 0", g, i, bus.step_en, bus.err);
        end
      end
    end
    pulses = 0;
    ups    = 2'b00;
    for (int i = 0; i < 17; i++) begin
      tick((i < FL + 1) ? 2'b01 : 2'b00, 1'b0, 1'b0);
      if (bus.step_en === 1'b1) begin
        if (pulses < 2) ups[pulses] = bus.step_up;
        pulses++;
      end
      n_checks++;
      if ({bus.step_en, bus.step_up, bus.err} !== {m_en, m_up, m_err}) begin
        n_fail++;
        $display("FAIL glitch_model cyc%0d: en/up/err=%b%b%b expected %b%b%b", i, bus.step_en, bus.step_up, bus.err, m_en, m_up, m_err);
      end
    end
    n_checks++;
    if (pulses !== 2 || ups !== 2'b01) begin
      n_fail++;
      $display("FAIL glitch_accept: pulses=%0d dirs(second,first)=%b expected 2 and 01", pulses, ups);
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 8; i++) begin
      tick(2'b11, 1'b0, 1'b0);
      n_checks++;
      if (bus.step_en !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_nostep cyc%0d: en=%b expected 0", i, bus.step_en);
      end
    end
    n_checks++;
    if (bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_err_set: err=%b expected 1", bus.err);
    end
    tick(2'b11, 1'b1, 1'b0);
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_err_clear: err=%b expected 0", bus.err);
    end
    for (int i = 0; i < 10; i++) begin
      tick(2'b00, (i == 7), 1'b0);
      n_checks++;
      if ({bus.step_en, bus.step_up, bus.err} !== {m_en, m_up, m_err}) begin
        n_fail++;
        $display("FAIL illegal_model cyc%0d: en/up/err=%b%b%b expected %b%b%b", i, bus.step_en, bus.step_up, bus.err, m_en, m_up, m_err);
      end
    end
    n_checks++;
    if (bus.err !== 1'b1 || bus.step_en !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_set_wins: err=%b en=%b expected 1 0", bus.err, bus.step_en);
    end
    tick(2'b00, 1'b1, 1'b0);
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_err_clear2: err=%b expected 0", bus.err);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b10, 1'b0, 1'b1);
    n_checks++;
    if (dut.state_q !== quad_pkg::QS_INIT || {bus.step_en, bus.step_up, bus.err} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_state: state=%0d en/up/err=%b%b%b expected 0 000", dut.state_q, bus.step_en, bus.step_up, bus.err);
    end
    for (int i = 0; i < 12; i++) begin
      tick(2'b10, 1'b0, 1'b0);
      n_checks++;
      if (bus.step_en !== 1'b0 || bus.err !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_noseed_step cyc%0d: en=%b err=%b expected 0 0", i, bus.step_en, bus.err);
      end
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(2'b11, 1'b0, 1'b0);
      if (bus.step_en === 1'b1) begin
        pulses++;
        n_checks++;
        if (bus.step_up !== 1'b0) begin
          n_fail++;
          $display("FAIL midreset_dir: up=%b expected 0", bus.step_up);
        end
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL midreset_resume: pulses=%0d expected 1", pulses);
    end
  endtask

  task automatic test_random();
    logic [1:0] cur, nxt;
    int r, hold;
    cur = 2'b11;
    for (int s = 0; s < 60; s++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      nxt = cur ^ 2'b11;
      else if (r < 3)  nxt = gray(gpos(cur) + 1);
      else             nxt = gray(gpos(cur) + (($urandom_range(0, 1) == 1) ? 1 : 3));
      hold = (r > 0 && r < 3) ? int'($urandom_range(1, FL)) : int'($urandom_range(FL + 1, 12));
      for (int i = 0; i < hold; i++) begin
        tick(nxt, ($urandom_range(0, 15) == 0), 1'b0);
        n_checks++;
        if ({bus.step_en, bus.step_up, bus.err} !== {m_en, m_up, m_err}) begin
          n_fail++;
          $display("FAIL random_model seg%0d cyc%0d: en/up/err=%b%b%b expected %b%b%b", s, i, bus.step_en, bus.step_up, bus.err, m_en, m_up, m_err);
        end
`ifdef QUAD_POSITION_EN
        n_checks++;
        if (bus.position !== m_pos) begin
          n_fail++;
          $display("FAIL random_position seg%0d: got %0h expected %0h", s, bus.position, m_pos);
        end
`endif
      end
      if (!(r > 0 && r < 3)) cur = nxt;
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.quad_a    = 1'b1;
    bus.quad_b    = 1'b1;
    bus.err_clear = 1'b0;
    test_reset();
    test_sequence(1'b1);
    test_sequence(1'b0);
    test_glitch();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
